mem_stage: RTL and testbench
============================

# mem_stage

The MEM pipeline stage of the 16-bit five-stage core. It holds the EX/MEM register and runs a req/ack handshake with a variable-latency data memory. It applies MEM-to-MEM store forwarding and stalls the pipeline while an access is outstanding. It produces the MEM/WB register that feeds write-back and the forwarding unit's MEM-hazard and MEM-to-MEM checks.

## Interface
Parameters:
- DATA_W, 16, datapath and address width
- REG_W, 4, register-ID width
- MAX_WAIT, 15, wait cycles before a request is declared hung

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ALU_result_EX  in  DATA_W  address or ALU result
- StoreData_EX  in  DATA_W  store data, already EX-forwarded
- DstReg1_EX, SrcReg2_EX  in  REG_W  destination and store-source register IDs
- RegWrite_EX, MemRead_EX, MemWrite_EX  in  1  control
- DMEM_fwd  in  1  from forwarding unit; replace store data with WB_data_MEMWB
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1
- dmem_ack  in  1  access complete this cycle
- dmem_addr, dmem_wdata  out  DATA_W  memory address and write data
- dmem_rd, dmem_wr  out  1  request strobes, held until ack
- RegWrite_EXMEM, MemRead_MEM, MemWrite_MEM  out  1  EX/MEM control
- DstReg1_in_from_EXMEM, SrcReg2_in_from_EXMEM  out  REG_W  EX/MEM register IDs
- ALU_result_EXMEM  out  DATA_W  EX/MEM result, used for EX-to-EX forwarding
- RegWrite_MEMWB  out  1  MEM/WB write enable
- DstReg1_in_from_MEMWB  out  REG_W  MEM/WB destination register
- WB_data_MEMWB  out  DATA_W  write-back data
- mem_stall  out  1  freeze PC, IF/ID and ID/EX this cycle
- mem_err  out  1  sticky: request exceeded MAX_WAIT

## Operation
- memop = MemRead_MEM | MemWrite_MEM.
- Request strobes: dmem_rd = MemRead_MEM & (state != HUNG); dmem_wr = MemWrite_MEM & (state != HUNG).
- dmem_addr = ALU_result_EXMEM.
- FSM states: IDLE, WAIT, HUNG.
- IDLE, memop=0: no request; mem_stall=0.
- IDLE, memop=1, dmem_ack=1: single-cycle completion; mem_stall=0; remain IDLE.
- IDLE, memop=1, dmem_ack=0: mem_stall=1; go to WAIT; latch wdata_q = DMEM_fwd ? WB_data_MEMWB : StoreData_EXMEM; clear wait_cnt.
- WAIT: mem_stall = ~dmem_ack; wait_cnt increments each cycle.
  - On dmem_ack, go to IDLE.
  - When wait_cnt == MAX_WAIT with no ack, go to HUNG and set mem_err.
- HUNG: mem_stall=1 and strobes low. Exit only via reset.
- dmem_wdata:
  - In IDLE: the live mux DMEM_fwd ? WB_data_MEMWB : StoreData_EXMEM.
  - In WAIT: wdata_q. MEM/WB fills with bubbles during a stall, so DMEM_fwd is not trusted after the first cycle.
- EX/MEM register: loads all *_EX inputs when mem_stall=0; holds when mem_stall=1.
- MEM/WB register, when mem_stall=0:
  - Loads RegWrite_EXMEM and DstReg1_in_from_EXMEM.
  - WB_data_MEMWB = MemRead_MEM ? dmem_rdata : ALU_result_EXMEM.
- MEM/WB register, when mem_stall=1: loads a bubble. RegWrite_MEMWB=0; DstReg and data hold their values.
- A stored value is never written back: MemWrite ops carry RegWrite=0 from decode. The block does not check this.

## Timing
- Reset (async assert, sync deassert external): state=IDLE, wait_cnt=0, mem_err=0.
- Reset also clears every EX/MEM and MEM/WB field. All outputs are therefore 0; strobes low, mem_stall=0.
- Non-memory ops and 1-cycle memory: EX/MEM to MEM/WB latency is 1 cycle, no stall.
- N-cycle memory (ack N cycles after strobe rises, N≥1): mem_stall is high for N cycles and the op leaves EX/MEM on the ack edge.
- Strobe, address and data are stable from strobe rise until the ack cycle inclusive.
- Back-to-back memory ops: the strobe stays high across the boundary. The next op's request starts in IDLE on the cycle after the ack.
- Ack with memop=0: ignored.
- Ack in HUNG: ignored.
- Reset mid-WAIT: the request is dropped immediately and asynchronously; no completion is recorded.

## Structure
- Shared package ic_pkg holds DATA_W/REG_W constants and the mem_state_t enum (IDLE, WAIT, HUNG).
- Sub-module mem_req_fsm holds state and wait_cnt, wdata_q capture, and the mem_stall/mem_err/strobe-gate outputs.
- The top level holds the EX/MEM and MEM/WB registers and the data muxes.

## Test plan
- ADD R3 then LW with memory ack same cycle: RegWrite_MEMWB=1 and DstReg1_in_from_MEMWB=3 one cycle after EX/MEM; mem_stall never asserts.
- LW R5, addr 0x0040, ack 3 cycles later, rdata=0xBEEF: mem_stall high 3 cycles with MEM/WB bubbles; then WB_data_MEMWB=0xBEEF, DstReg=5, RegWrite_MEMWB=1.
- LW R2 (data 0x1234) then SW R2 with DMEM_fwd=1 and a 4-cycle memory: dmem_wdata=0x1234 on every strobe cycle, although RegWrite_MEMWB drops after cycle 1.
- No ack for 16 cycles after a SW strobe: mem_err=1 and the strobe drops at MAX_WAIT; mem_stall stays 1 until rst_n low.
- rst_n low during cycle 2 of WAIT: all outputs 0 immediately; after release a new LW completes normally.
- Ack pulsed with no memop pending: no state change, no MEM/WB data corruption.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared constants and state encoding for the core's pipeline-stage blocks.
package ic_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 4;
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HUNG = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: stall generation, hang timeout, write-data capture.
//  state | meaning
//  IDLE  | no access outstanding; a memop either completes now or starts waiting
//  WAIT  | request outstanding, strobe held, counting cycles until ack
//  HUNG  | ack never arrived within MAX_WAIT; pipeline frozen until reset
module mem_req_fsm
    import ic_pkg::*;
#(
    parameter int DATA_W   = ic_pkg::DATA_W,
    parameter int MAX_WAIT = ic_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              dmemAck,
    input  logic              dmemFwd,
    input  logic [DATA_W-1:0] fwdData,
    input  logic [DATA_W-1:0] storeData,
    output logic              memStall,
    output logic              memErr,
    output logic              dmemRd,
    output logic              dmemWr,
    output logic [DATA_W-1:0] wdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_t        state, stateNxt;
    logic [CNT_W-1:0]  waitCnt, waitCntNxt;
    logic [DATA_W-1:0] wdataQ, wdataQNxt;
    logic              memErrQ, memErrNxt;
    logic              memOp;
    logic [DATA_W-1:0] liveWdata;

    assign memOp     = memRead | memWrite;
    assign liveWdata = dmemFwd ? fwdData : storeData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            waitCnt <= '0;
            wdataQ  <= '0;
            memErrQ <= 1'b0;
        end else begin
            state   <= stateNxt;
            waitCnt <= waitCntNxt;
            wdataQ  <= wdataQNxt;
            memErrQ <= memErrNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        waitCntNxt = waitCnt;
        wdataQNxt  = wdataQ;
        memErrNxt  = memErrQ;
        memStall   = 1'b0;
        case (state)
            IDLE: begin
                if (memOp && !dmemAck) begin
                    memStall   = 1'b1;
                    stateNxt   = WAIT;
                    wdataQNxt  = liveWdata;
                    waitCntNxt = '0;
                end
            end
            WAIT: begin
                memStall = ~dmemAck;
                if (dmemAck) begin
                    stateNxt = IDLE;
                end else if (waitCnt == CNT_W'(MAX_WAIT)) begin
                    stateNxt  = HUNG;
                    memErrNxt = 1'b1;
                end else begin
                    waitCntNxt = waitCnt + 1'b1;
                end
            end
            HUNG: begin
                memStall = 1'b1;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // Forwarded WB data is only trustworthy on the first cycle; MEM/WB bubbles after that.
    assign wdata  = (state == IDLE) ? liveWdata : wdataQ;
    assign dmemRd = memRead  && (state != HUNG);
    assign dmemWr = memWrite && (state != HUNG);
    assign memErr = memErrQ;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a req/ack data memory.
module mem_stage
    import ic_pkg::*;
#(
    parameter int DATA_W   = ic_pkg::DATA_W,
    parameter int REG_W    = ic_pkg::REG_W,
    parameter int MAX_WAIT = ic_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALU_result_EX,
    input  logic [DATA_W-1:0] StoreData_EX,
    input  logic [REG_W-1:0]  DstReg1_EX,
    input  logic [REG_W-1:0]  SrcReg2_EX,
    input  logic              RegWrite_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              DMEM_fwd,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic              RegWrite_EXMEM,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic [REG_W-1:0]  DstReg1_in_from_EXMEM,
    output logic [REG_W-1:0]  SrcReg2_in_from_EXMEM,
    output logic [DATA_W-1:0] ALU_result_EXMEM,
    output logic              RegWrite_MEMWB,
    output logic [REG_W-1:0]  DstReg1_in_from_MEMWB,
    output logic [DATA_W-1:0] WB_data_MEMWB,
    output logic              mem_stall,
    output logic              mem_err
);

    logic [DATA_W-1:0] storeDataExMem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_result_EXMEM      <= '0;
            storeDataExMem        <= '0;
            DstReg1_in_from_EXMEM <= '0;
            SrcReg2_in_from_EXMEM <= '0;
            RegWrite_EXMEM        <= 1'b0;
            MemRead_MEM           <= 1'b0;
            MemWrite_MEM          <= 1'b0;
        end else if (!mem_stall) begin
            ALU_result_EXMEM      <= ALU_result_EX;
            storeDataExMem        <= StoreData_EX;
            DstReg1_in_from_EXMEM <= DstReg1_EX;
            SrcReg2_in_from_EXMEM <= SrcReg2_EX;
            RegWrite_EXMEM        <= RegWrite_EX;
            MemRead_MEM           <= MemRead_EX;
            MemWrite_MEM          <= MemWrite_EX;
        end
    end

    // A stall inserts a bubble into MEM/WB; only the write enable needs clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_MEMWB        <= 1'b0;
            DstReg1_in_from_MEMWB <= '0;
            WB_data_MEMWB         <= '0;
        end else if (mem_stall) begin
            RegWrite_MEMWB        <= 1'b0;
        end else begin
            RegWrite_MEMWB        <= RegWrite_EXMEM;
            DstReg1_in_from_MEMWB <= DstReg1_in_from_EXMEM;
            WB_data_MEMWB         <= MemRead_MEM ? dmem_rdata : ALU_result_EXMEM;
        end
    end

    assign dmem_addr = ALU_result_EXMEM;

    mem_req_fsm #(
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_req_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (MemRead_MEM),
        .memWrite  (MemWrite_MEM),
        .dmemAck   (dmem_ack),
        .dmemFwd   (DMEM_fwd),
        .fwdData   (WB_data_MEMWB),
        .storeData (storeDataExMem),
        .memStall  (mem_stall),
        .memErr    (mem_err),
        .dmemRd    (dmem_rd),
        .dmemWr    (dmem_wr),
        .wdata     (dmem_wdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed op list, memory responder, request/write-back monitors.
module tb_mem_stage;
    import ic_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ALU_result_EX, StoreData_EX, dmem_rdata;
    logic [3:0]  DstReg1_EX, SrcReg2_EX;
    logic        RegWrite_EX, MemRead_EX, MemWrite_EX, DMEM_fwd, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, ALU_result_EXMEM, WB_data_MEMWB;
    logic        dmem_rd, dmem_wr, RegWrite_EXMEM, MemRead_MEM, MemWrite_MEM;
    logic [3:0]  DstReg1_in_from_EXMEM, SrcReg2_in_from_EXMEM, DstReg1_in_from_MEMWB;
    logic        RegWrite_MEMWB, mem_stall, mem_err;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_result_EX(ALU_result_EX), .StoreData_EX(StoreData_EX),
        .DstReg1_EX(DstReg1_EX), .SrcReg2_EX(SrcReg2_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .DMEM_fwd(DMEM_fwd), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .RegWrite_EXMEM(RegWrite_EXMEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .DstReg1_in_from_EXMEM(DstReg1_in_from_EXMEM), .SrcReg2_in_from_EXMEM(SrcReg2_in_from_EXMEM),
        .ALU_result_EXMEM(ALU_result_EXMEM), .RegWrite_MEMWB(RegWrite_MEMWB),
        .DstReg1_in_from_MEMWB(DstReg1_in_from_MEMWB), .WB_data_MEMWB(WB_data_MEMWB),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, mr, mw, fwd, spur;
        logic [15:0] alu, sd, rdata, expData, expWdata;
        logic [3:0]  dst, src;
        int          lat;
    } op_t;
    typedef struct { logic rd, wr; logic [15:0] addr, wdata; } req_t;
    typedef struct { logic [3:0] dst; logic [15:0] data; } wb_t;

    req_t expReq[$];
    wb_t  expWb[$];
    op_t  ops[9];
    int   nChecks = 0;
    int   nErrors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks = nChecks + 1;
        if (act !== exp) begin
            nErrors = nErrors + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(int rw, int mr, int mw, int alu, int sd, int dst, int src,
                               int lat, int rdata, int fwd, int spur, int expData, int expWdata);
        op_t o;
        o.valid = 1'b1;   o.rw = rw[0];   o.mr = mr[0];   o.mw = mw[0];
        o.fwd = fwd[0];   o.spur = spur[0];
        o.alu = alu[15:0];  o.sd = sd[15:0];  o.rdata = rdata[15:0];
        o.expData = expData[15:0];  o.expWdata = expWdata[15:0];
        o.dst = dst[3:0];  o.src = src[3:0];  o.lat = lat;
        return o;
    endfunction

    function automatic op_t bubbleOp();
        op_t o;
        o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o.valid = 1'b0;
        return o;
    endfunction

    task automatic driveEx(input op_t o);
        ALU_result_EX = o.alu;  StoreData_EX = o.sd;
        DstReg1_EX = o.dst;     SrcReg2_EX = o.src;
        RegWrite_EX = o.rw;     MemRead_EX = o.mr;  MemWrite_EX = o.mw;
    endtask

    // Monitor: every strobe cycle must match the oldest outstanding request;
    // every MEM/WB write must match the oldest expected write-back.
    always @(negedge clk) begin
        req_t r;
        wb_t  w;
        if (rst_n) begin
            if (dmem_rd || dmem_wr) begin
                chk("req_expected", 32'(expReq.size() != 0), 32'(1));
                if (expReq.size() != 0) begin
                    r = expReq[0];
                    chk("req_rd", 32'(dmem_rd), 32'(r.rd));
                    chk("req_wr", 32'(dmem_wr), 32'(r.wr));
                    chk("req_addr", 32'(dmem_addr), 32'(r.addr));
                    if (r.wr) chk("req_wdata", 32'(dmem_wdata), 32'(r.wdata));
                    if (dmem_ack) void'(expReq.pop_front());
                end
            end
            if (RegWrite_MEMWB) begin
                chk("wb_expected", 32'(expWb.size() != 0), 32'(1));
                if (expWb.size() != 0) begin
                    w = expWb.pop_front();
                    chk("wb_dst", 32'(DstReg1_in_from_MEMWB), 32'(w.dst));
                    chk("wb_data", 32'(WB_data_MEMWB), 32'(w.data));
                end
            end
        end
    end

    // Driver + memory responder; called and returns at posedge+1 with an empty pipe.
    task automatic runOps(input int lo, input int hi);
        op_t  m, b, nx;
        req_t r;
        wb_t  w;
        int   nxt, waitCyc, drain;
        logic expStall, done;
        b = bubbleOp();
        m = b;  nxt = lo;  waitCyc = 0;  drain = 0;  done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (nxt <= hi) nx = ops[nxt]; else nx = b;
            driveEx(nx);
            expStall   = (m.mr | m.mw) && (waitCyc < m.lat);
            dmem_ack   = (m.mr | m.mw) ? (waitCyc == m.lat) : m.spur;
            dmem_rdata = m.rdata;
            DMEM_fwd   = m.fwd && (waitCyc == 0);
            @(negedge clk);
            chk("mem_stall", 32'(mem_stall), 32'(expStall));
            @(posedge clk); #1;
            if (!expStall) begin
                m = nx;
                if (nxt <= hi) nxt++;
                waitCyc = 0;
                if (m.mr | m.mw) begin
                    r.rd = m.mr;  r.wr = m.mw;  r.addr = m.alu;  r.wdata = m.expWdata;
                    expReq.push_back(r);
                end
                if (m.rw) begin
                    w.dst = m.dst;  w.data = m.expData;
                    expWb.push_back(w);
                end
                if (nxt > hi && !m.valid) begin
                    drain++;
                    if (drain == 2) done = 1'b1;
                end
            end else begin
                waitCyc++;
            end
        end
        chk("drain_budget", 32'(done), 32'(1));
        dmem_ack = 1'b0;  DMEM_fwd = 1'b0;  dmem_rdata = '0;
        driveEx(b);
    endtask

    initial begin
        op_t b;
        req_t r;
        b = bubbleOp();
        rst_n = 1'b0;
        driveEx(b);
        DMEM_fwd = 1'b0;  dmem_ack = 1'b0;  dmem_rdata = '0;

        //                rw mr mw  alu      sd       dst src lat rdata   fwd spur expData  expWdata
        ops[0] = mk(1, 0, 0, 'h0011, 0,      3, 0, 0, 0,      0, 0, 'h0011, 0);
        ops[1] = mk(1, 1, 0, 'h0020, 0,      4, 0, 0, 'h5555, 0, 0, 'h5555, 0);
        ops[2] = mk(1, 1, 0, 'h0040, 0,      5, 0, 3, 'hBEEF, 0, 0, 'hBEEF, 0);
        ops[3] = mk(1, 1, 0, 'h0050, 0,      2, 0, 1, 'h1234, 0, 0, 'h1234, 0);
        ops[4] = mk(0, 0, 1, 'h0060, 'hDEAD, 0, 2, 4, 0,      1, 0, 0,      'h1234);
        ops[5] = mk(1, 0, 0, 'h0ABC, 0,      7, 0, 0, 'hFFFF, 0, 1, 'h0ABC, 0);
        ops[6] = mk(0, 0, 1, 'h0070, 'h4321, 0, 3, 0, 0,      0, 0, 0,      'h4321);
        ops[7] = mk(1, 1, 0, 'h0080, 0,      1, 0, 2, 'h00FF, 0, 0, 'h00FF, 0);
        ops[8] = mk(1, 1, 0, 'h00B0, 0,      6, 0, 1, 'h6666, 0, 0, 'h6666, 0);

        #1;
        chk("rst_stall", 32'(mem_stall), 32'(0));
        chk("rst_err", 32'(mem_err), 32'(0));
        chk("rst_strobes", 32'({dmem_rd, dmem_wr}), 32'(0));
        chk("rst_wb_we", 32'(RegWrite_MEMWB), 32'(0));
        chk("rst_wb_data", 32'(WB_data_MEMWB), 32'(0));
        chk("rst_addr", 32'(dmem_addr), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        runOps(0, 7);

        // Store that never completes: strobe up for cycles 0..16, then HUNG.
        r.rd = 1'b0;  r.wr = 1'b1;  r.addr = 16'h0090;  r.wdata = 16'h7777;
        expReq.push_back(r);
        ALU_result_EX = 16'h0090;  StoreData_EX = 16'h7777;  MemWrite_EX = 1'b1;
        @(posedge clk); #1;
        driveEx(b);
        for (int k = 0; k < 25; k++) begin
            dmem_ack = (k == 20);
            @(negedge clk);
            if (k == 16) begin
                chk("hang_wr_last", 32'(dmem_wr), 32'(1));
                chk("hang_err_pre", 32'(mem_err), 32'(0));
            end
            if (k == 17) begin
                chk("hang_wr_drop", 32'(dmem_wr), 32'(0));
                chk("hang_err", 32'(mem_err), 32'(1));
                chk("hang_stall", 32'(mem_stall), 32'(1));
            end
            if (k == 24) begin
                chk("hung_ack_ignored", 32'(mem_stall), 32'(1));
                chk("hung_err_sticky", 32'(mem_err), 32'(1));
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("hung_rst_stall", 32'(mem_stall), 32'(0));
        chk("hung_rst_err", 32'(mem_err), 32'(0));
        expReq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset during the second WAIT cycle of a slow load.
        r.rd = 1'b1;  r.wr = 1'b0;  r.addr = 16'h00A0;  r.wdata = 16'h0000;
        expReq.push_back(r);
        ALU_result_EX = 16'h00A0;  DstReg1_EX = 4'd6;  RegWrite_EX = 1'b1;  MemRead_EX = 1'b1;
        @(posedge clk); #1;
        driveEx(b);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_stall", 32'(mem_stall), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_rd", 32'(dmem_rd), 32'(0));
        chk("midrst_stall", 32'(mem_stall), 32'(0));
        chk("midrst_addr", 32'(dmem_addr), 32'(0));
        chk("midrst_memread", 32'(MemRead_MEM), 32'(0));
        chk("midrst_dst", 32'(DstReg1_in_from_EXMEM), 32'(0));
        chk("midrst_wb_we", 32'(RegWrite_MEMWB), 32'(0));
        expReq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        runOps(8, 8);

        chk("req_queue_empty", 32'(expReq.size()), 32'(0));
        chk("wb_queue_empty", 32'(expWb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", nChecks, nErrors);
        $fatal(1, "watchdog");
    end

endmodule
